// File: rtl/ram_io_timer.sv
// ram_io_timer: 8155-class static RAM plus down-counting timer on a multiplexed AD bus.
// Define RAM_PARITY_EN to store an even-parity bit per RAM word and raise a sticky parity_err.
module ram_io_timer #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMER_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] ad,
    input  logic              ale,
    input  logic              csn,
    input  logic              rdn,
    input  logic              wrn,
    input  logic              iomn,
    input  logic              tick,
    output logic              timer_out,
    output logic              busy,
    output logic              parity_err
);

    // state | meaning
    // CLEAR | zeroing RAM one word per clk from ptr=0, busy=1
    // IDLE  | normal bus and timer operation

    localparam int DEPTH = 2**ADDR_W;
    localparam int HI_W  = TIMER_W - DATA_W;
`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   ptr;
    logic                clr_we;

    logic [MEM_W-1:0]    mem [DEPTH];
    logic [MEM_W-1:0]    mem_word;
    logic [MEM_W-1:0]    wr_word;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   ad_addr;
    logic [DATA_W-1:0]   rd_q;
    logic [DATA_W-1:0]   target;

    logic                acc_wr, acc_rd, reg_wr, ram_we, pe_set;
    logic                stat_rd, stat_rd_q, stat_clr;
    logic                cmd_wr, stop_req;
    logic [1:0]          cmd;

    logic [DATA_W-1:0]   count_lo;
    logic [HI_W-1:0]     count_hi;
    logic                mode, running, stop_pend, tc, pe;
    logic [TIMER_W-1:0]  cnt, raw_load, load_val;

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   if (ptr == '1) state_nx = IDLE;
            IDLE:    state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    always_comb begin
        busy   = (state == CLEAR);
        clr_we = (state == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst)         ptr <= '0;
        else if (clr_we) ptr <= ptr + ADDR_W'(1);
    end

    generate
        if (ADDR_W > DATA_W) begin : g_addr_wide
            assign ad_addr = {{(ADDR_W-DATA_W){1'b0}}, ad};
        end else begin : g_addr_narrow
            assign ad_addr = ad[ADDR_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)      addr_q <= '0;
        else if (ale) addr_q <= ad_addr;
    end

    // A simultaneous read and write strobe is treated as a write only.
    assign acc_wr = ~csn & ~wrn;
    assign acc_rd = ~csn & ~rdn & wrn;
    assign reg_wr = acc_wr & iomn & ~rst;
    assign ram_we = acc_wr & ~iomn & ~busy & ~rst;
    assign mem_word = mem[addr_q];

`ifdef RAM_PARITY_EN
    assign wr_word = {^ad, ad};
    assign pe_set  = acc_rd & ~iomn & ~busy & (^mem_word);
`else
    assign wr_word = ad;
    assign pe_set  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr_we)      mem[ptr]    <= '0;
        else if (ram_we) mem[addr_q] <= wr_word;
    end

    always_comb begin
        target = '0;
        if (!iomn) begin
            if (!busy) target = mem_word[DATA_W-1:0];
        end else begin
            case (addr_q[2:0])
                3'd0: begin
                    target[DATA_W-1] = tc;
                    target[DATA_W-2] = running;
                    target[DATA_W-3] = pe;
                end
                3'd4: target = count_lo;
                3'd5: begin
                    target[DATA_W-1] = mode;
                    target[HI_W-1:0] = count_hi;
                end
                default: target = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_q <= '0;
        else     rd_q <= target;
    end

    assign ad = acc_rd ? rd_q : 'z;

    // Status flags clear when the status read strobe is released.
    assign stat_rd  = acc_rd & iomn & (addr_q[2:0] == 3'd0);
    assign stat_clr = stat_rd_q & rdn;

    always_ff @(posedge clk) begin
        if (rst) stat_rd_q <= 1'b0;
        else     stat_rd_q <= stat_rd;
    end

    always_ff @(posedge clk) begin
        if (rst)           pe <= 1'b0;
        else if (pe_set)   pe <= 1'b1;
        else if (stat_clr) pe <= 1'b0;
    end

    assign parity_err = pe;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_lo <= '0;
            count_hi <= '0;
            mode     <= 1'b0;
        end else if (reg_wr) begin
            case (addr_q[2:0])
                3'd4: count_lo <= ad;
                3'd5: begin
                    mode     <= ad[DATA_W-1];
                    count_hi <= ad[HI_W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign cmd_wr   = reg_wr & (addr_q[2:0] == 3'd0);
    assign cmd      = ad[DATA_W-1:DATA_W-2];
    assign stop_req = stop_pend | (cmd_wr & (cmd == 2'b10));
    assign raw_load = {count_hi, count_lo};
    assign load_val = (raw_load < TIMER_W'(2)) ? TIMER_W'(2) : raw_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            running   <= 1'b0;
            stop_pend <= 1'b0;
            cnt       <= '0;
            tc        <= 1'b0;
            timer_out <= 1'b0;
        end else begin
            timer_out <= 1'b0;
            if (stat_clr) tc <= 1'b0;
            if (cmd_wr && cmd == 2'b11) begin
                cnt       <= load_val;
                running   <= 1'b1;
                stop_pend <= 1'b0;
            end else if (cmd_wr && cmd == 2'b01) begin
                running   <= 1'b0;
                stop_pend <= 1'b0;
            end else begin
                if (cmd_wr && cmd == 2'b10 && running) stop_pend <= 1'b1;
                if (running && tick) begin
                    if (cnt == TIMER_W'(1)) begin
                        timer_out <= 1'b1;
                        tc        <= 1'b1;
                        if (mode && !stop_req) begin
                            cnt <= load_val;
                        end else begin
                            running   <= 1'b0;
                            stop_pend <= 1'b0;
                            cnt       <= '0;
                        end
                    end else begin
                        cnt <= cnt - TIMER_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_io_timer.sv
// tb_ram_io_timer: directed bench for ram_io_timer (RAM clear, bus timing, timer modes).
// Define RAM_PARITY_EN for both files to exercise the parity path.
module tb_ram_io_timer;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst, ale, csn, rdn, wrn, iomn;
    logic tick = 1'b0;
    logic tick_alt = 1'b0;
    logic tick_lvl = 1'b0;
    logic timer_out, busy, parity_err;
    wire  [DW-1:0] ad;
    logic [DW-1:0] drv;
    logic drv_en;
    int checks = 0;
    int errors = 0;

    assign ad = drv_en ? drv : 'z;

    // Released bus reads back as all ones.
    generate
        for (genvar i = 0; i < DW; i++) begin : g_pu
            pullup pu (ad[i]);
        end
    endgenerate

    ram_io_timer #(.DATA_W(8), .ADDR_W(8), .TIMER_W(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .ad         (ad),
        .ale        (ale),
        .csn        (csn),
        .rdn        (rdn),
        .wrn        (wrn),
        .iomn       (iomn),
        .tick       (tick),
        .timer_out  (timer_out),
        .busy       (busy),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) tick = tick_alt ? ~tick : tick_lvl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic latch(input logic [DW-1:0] a, input logic io);
        @(negedge clk);
        iomn = io; ale = 1'b1; drv = a; drv_en = 1'b1;
        @(negedge clk);
        ale = 1'b0; drv_en = 1'b0;
    endtask

    task automatic wr(input logic [DW-1:0] a, input logic [DW-1:0] d, input logic io);
        latch(a, io);
        drv = d; drv_en = 1'b1; csn = 1'b0; wrn = 1'b0;
        @(negedge clk);
        csn = 1'b1; wrn = 1'b1; drv_en = 1'b0;
    endtask

    task automatic rd(input logic [DW-1:0] a, input logic io, output logic [DW-1:0] d);
        latch(a, io);
        csn = 1'b0; rdn = 1'b0;
        @(posedge clk);
        #1 d = ad;
        @(negedge clk);
        csn = 1'b1; rdn = 1'b1;
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!timer_out && n < 100);
    endtask

    task automatic count_pulses(input int cycles, output int p);
        p = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1 if (timer_out) p++;
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        int n;
        int bad;

        rst = 1'b1; ale = 1'b0; csn = 1'b1; rdn = 1'b1; wrn = 1'b1;
        iomn = 1'b0; drv = '0; drv_en = 1'b0;

        @(posedge clk);
        #1;
        check("rst_busy", busy, 1);
        check("rst_timer_out", timer_out, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_ad_hiz", ad, 8'hFF);
        rst = 1'b0;

        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (busy && n < 1000);
        check("clear_cycles", n, 256);

        bad = 0;
        for (int a = 0; a < 256; a++) begin
            rd(8'(a), 1'b0, d);
            if (d !== 8'h00) bad++;
        end
        check("ram_all_zero", bad, 0);

        wr(8'h3C, 8'hA5, 1'b0);
        rd(8'h3C, 1'b0, d);
        check("ram_rd_3c", d, 8'hA5);
        #1 check("ad_hiz_after_rd", ad, 8'hFF);

        latch(8'h3C, 1'b0);
        csn = 1'b0; rdn = 1'b0; wrn = 1'b0;
        #1 check("rdwr_hiz", ad, 8'hFF);
        drv = 8'h66; drv_en = 1'b1;
        @(negedge clk);
        csn = 1'b1; rdn = 1'b1; wrn = 1'b1; drv_en = 1'b0;
        rd(8'h3C, 1'b0, d);
        check("rdwr_write_won", d, 8'h66);

        wr(8'hF0, 8'h5A, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst2_busy", busy, 1);
        wr(8'h00, 8'h77, 1'b0);
        rd(8'hF0, 1'b0, d);
        check("busy_rd_zero", d, 8'h00);
        n = 0;
        while (busy && n < 1000) begin
            @(posedge clk);
            #1 n++;
        end
        check("clear2_done", busy, 0);
        rd(8'h00, 1'b0, d);
        check("busy_wr_dropped", d, 8'h00);
        rd(8'hF0, 1'b0, d);
        check("clear2_f0", d, 8'h00);

        tick_lvl = 1'b1;
        wr(8'h04, 8'h05, 1'b1);
        wr(8'h05, 8'h00, 1'b1);
        rd(8'h04, 1'b1, d);
        check("count_lo_rd", d, 8'h05);
        wr(8'h00, 8'hC0, 1'b1);
        wait_pulse(n);
        check("oneshot_latency", n, 5);
        @(posedge clk);
        #1 check("pulse_width", timer_out, 0);
        rd(8'h00, 1'b1, d);
        check("status_tc", d, 8'h80);
        rd(8'h00, 1'b1, d);
        check("status_cleared", d, 8'h00);

        wr(8'h04, 8'h01, 1'b1);
        wr(8'h00, 8'hC0, 1'b1);
        wait_pulse(n);
        check("count1_as_2", n, 2);

        wr(8'h04, 8'h03, 1'b1);
        wr(8'h05, 8'h80, 1'b1);
        rd(8'h05, 1'b1, d);
        check("reg5_rd", d, 8'h80);
        tick_alt = 1'b1;
        wr(8'h00, 8'hC0, 1'b1);
        wait_pulse(n);
        wait_pulse(n);
        check("period_1", n, 6);
        wait_pulse(n);
        check("period_2", n, 6);
        wr(8'h00, 8'h40, 1'b1);
        count_pulses(30, n);
        check("stop_now", n, 0);

        wr(8'h00, 8'hC0, 1'b1);
        wr(8'h00, 8'h80, 1'b1);
        count_pulses(40, n);
        check("stop_at_tc", n, 1);

`ifdef RAM_PARITY_EN
        tick_alt = 1'b0;
        tick_lvl = 1'b0;
        rd(8'h00, 1'b1, d);
        wr(8'h10, 8'h0F, 1'b0);
        dut.mem[16] = dut.mem[16] ^ 9'h001;
        rd(8'h10, 1'b0, d);
        check("pe_data", d, 8'h0E);
        check("pe_out", parity_err, 1);
        rd(8'h00, 1'b1, d);
        check("status_pe", d, 8'h20);
        rd(8'h00, 1'b1, d);
        check("status_pe_clr", d, 8'h00);
        check("pe_out_clr", parity_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
